// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA raster timing generator.
package vga_pkg;

    // Default 640x480@60 Hz timing, in pixels and lines.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Coordinate width and the largest total the counters can represent.
    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    // Raw (pre-polarity) control bits that travel down the delay line.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } vga_ctl_t;

    // Blanked, sync deasserted: what a freshly reset pipe holds.
    localparam vga_ctl_t CTL_IDLE = '{active: 1'b0, hs: 1'b0, vs: 1'b0};

    // Total pixels per line or lines per frame.
    function automatic int total_of(input int active, input int fp,
                                    input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to its consumers.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic               pix_en;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic               line_start;
    logic               frame_start;
    logic               video_active;
    logic               h_sync;
    logic               v_sync;

    modport master (
        output pix_en, pixel_x, pixel_y, line_start, frame_start,
               video_active, h_sync, v_sync
    );

    modport slave (
        input  pix_en, pixel_x, pixel_y, line_start, frame_start,
               video_active, h_sync, v_sync
    );

endinterface

// File: rtl/vga_timing_gen_sig_delay.sv
// Generic fixed-depth shift register with asynchronous active-low reset.
module sig_delay #(
    parameter int               WIDTH       = 1,
    parameter int               DEPTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK_50,
    input  logic             resetN,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift every clock; reset loads every stage with the idle value.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RESET_VALUE;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel enable, h/v counters, and sync/blank
// decode delayed to line up with the pixel data path.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE        = DEF_H_ACTIVE,
    parameter int H_FP            = DEF_H_FP,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BP            = DEF_H_BP,
    parameter int V_ACTIVE        = DEF_V_ACTIVE,
    parameter int V_FP            = DEF_V_FP,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BP            = DEF_V_BP,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int PIPE_DELAY      = 2
) (
    input  logic             CLK_50,
    input  logic             resetN,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = total_of(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total_of(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX ||
        PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_param_err
        $error("vga_timing_gen: totals exceed counter range or PIPE_DELAY not in 1..4");
    end

    localparam int EXT_W = COORD_W + 1;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    // One extra bit so a region edge equal to 1024 still compares correctly.
    localparam logic [EXT_W-1:0] H_ACT_E  = EXT_W'(H_ACTIVE);
    localparam logic [EXT_W-1:0] HS_BEG_E = EXT_W'(H_ACTIVE + H_FP);
    localparam logic [EXT_W-1:0] HS_END_E = EXT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [EXT_W-1:0] V_ACT_E  = EXT_W'(V_ACTIVE);
    localparam logic [EXT_W-1:0] VS_BEG_E = EXT_W'(V_ACTIVE + V_FP);
    localparam logic [EXT_W-1:0] VS_END_E = EXT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic               pix_en_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [EXT_W-1:0]   x_e;
    logic [EXT_W-1:0]   y_e;
    vga_ctl_t           ctl_raw;
    vga_ctl_t           ctl_dly;

    // Pixel enable toggles every clock; counters advance on enabled edges.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            pix_en_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            pix_en_q <= ~pix_en_q;
            if (pix_en_q) begin
                if (x_q == H_LAST) begin
                    x_q <= '0;
                    if (y_q == V_LAST) begin
                        y_q <= '0;
                    end else begin
                        y_q <= y_q + COORD_W'(1);
                    end
                end else begin
                    x_q <= x_q + COORD_W'(1);
                end
            end
        end
    end

    assign x_e = {1'b0, x_q};
    assign y_e = {1'b0, y_q};

    // Region decode from the undelayed counters, raw (active-high) sense.
    always_comb begin
        ctl_raw        = CTL_IDLE;
        ctl_raw.active = (x_e < H_ACT_E) && (y_e < V_ACT_E);
        ctl_raw.hs     = (x_e >= HS_BEG_E) && (x_e < HS_END_E);
        ctl_raw.vs     = (y_e >= VS_BEG_E) && (y_e < VS_END_E);
    end

    // Delay matches the RAM read plus overlay latency on the pixel path.
    sig_delay #(
        .WIDTH       ($bits(vga_ctl_t)),
        .DEPTH       (PIPE_DELAY),
        .RESET_VALUE (CTL_IDLE)
    ) u_ctl_delay (
        .CLK_50 (CLK_50),
        .resetN (resetN),
        .din    (ctl_raw),
        .dout   (ctl_dly)
    );

    assign vga.pix_en       = pix_en_q;
    assign vga.pixel_x      = x_q;
    assign vga.pixel_y      = y_q;
    assign vga.line_start   = pix_en_q && (x_q == '0);
    assign vga.frame_start  = pix_en_q && (x_q == '0) && (y_q == '0);
    assign vga.video_active = ctl_dly.active;
    // Polarity is applied after the delay so idle stages read as deasserted.
    assign vga.h_sync       = ctl_dly.hs ^ SYNC_ACTIVE_LOW;
    assign vga.v_sync       = ctl_dly.vs ^ SYNC_ACTIVE_LOW;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, PIPE_DELAY=3,
// active-high syncs, and a shrunken raster for whole-frame behaviour.
module tb_vga_timing_gen;

    logic CLK_50 = 1'b0;
    logic resetN;

    always #10 CLK_50 = ~CLK_50;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();
    vga_timing_gen_if if_d ();

    vga_timing_gen dut_a (.CLK_50(CLK_50), .resetN(resetN), .vga(if_a));

    vga_timing_gen #(.PIPE_DELAY(3))
        dut_b (.CLK_50(CLK_50), .resetN(resetN), .vga(if_b));

    vga_timing_gen #(.SYNC_ACTIVE_LOW(1'b0))
        dut_c (.CLK_50(CLK_50), .resetN(resetN), .vga(if_c));

    // 16 pixels x 8 lines: frame period 256 clocks.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DELAY(2)
    ) dut_d (.CLK_50(CLK_50), .resetN(resetN), .vga(if_d));

    typedef struct {
        int   k;       // posedge count since reset release
        logic pix_en;
        int   x;
        int   y;
        logic ls;
        logic fs;
        logic va;
        logic hs_n;
        logic vs_n;
        logic b_va;    // video_active of the PIPE_DELAY=3 instance
    } vec_t;

    vec_t tbl [15];

    int n_cmp   = 0;
    int n_bad   = 0;
    int inv_n   = 0;
    int inv_bad = 0;
    int ka, kd, km;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step_to(inout int k, input int target);
        while (k < target) begin
            @(posedge CLK_50);
            k++;
        end
        #1;
    endtask

    task automatic run_vec(input int lo, input int hi, inout int k);
        for (int i = lo; i <= hi; i++) begin
            step_to(k, tbl[i].k);
            check($sformatf("k%0d pix_en", tbl[i].k),       int'(if_a.pix_en),       int'(tbl[i].pix_en));
            check($sformatf("k%0d pixel_x", tbl[i].k),      int'(if_a.pixel_x),      tbl[i].x);
            check($sformatf("k%0d pixel_y", tbl[i].k),      int'(if_a.pixel_y),      tbl[i].y);
            check($sformatf("k%0d line_start", tbl[i].k),   int'(if_a.line_start),   int'(tbl[i].ls));
            check($sformatf("k%0d frame_start", tbl[i].k),  int'(if_a.frame_start),  int'(tbl[i].fs));
            check($sformatf("k%0d video_active", tbl[i].k), int'(if_a.video_active), int'(tbl[i].va));
            check($sformatf("k%0d h_sync", tbl[i].k),       int'(if_a.h_sync),       int'(tbl[i].hs_n));
            check($sformatf("k%0d v_sync", tbl[i].k),       int'(if_a.v_sync),       int'(tbl[i].vs_n));
            check($sformatf("k%0d b video_active", tbl[i].k), int'(if_b.video_active), int'(tbl[i].b_va));
        end
    endtask

    // Active-high instance must be the bitwise inverse of the default one.
    always @(negedge CLK_50) begin
        inv_n++;
        if (if_c.h_sync !== ~if_a.h_sync || if_c.v_sync !== ~if_a.v_sync)
            inv_bad++;
    end

    initial begin
        int fs_cnt, vlow, hlow, first_fs, fs_gap, ls_cnt;

        //              k    pe  x    y  ls fs va hs vs bva
        tbl[0]  = '{   1, 1,   0, 0, 1, 1, 0, 1, 1, 0};
        tbl[1]  = '{   2, 0,   1, 0, 0, 0, 1, 1, 1, 0};
        tbl[2]  = '{   3, 1,   1, 0, 0, 0, 1, 1, 1, 1};
        tbl[3]  = '{1280, 0, 640, 0, 0, 0, 1, 1, 1, 1};
        tbl[4]  = '{1281, 1, 640, 0, 0, 0, 1, 1, 1, 1};
        tbl[5]  = '{1282, 0, 641, 0, 0, 0, 0, 1, 1, 1};
        tbl[6]  = '{1283, 1, 641, 0, 0, 0, 0, 1, 1, 0};
        tbl[7]  = '{1312, 0, 656, 0, 0, 0, 0, 1, 1, 0};
        tbl[8]  = '{1314, 0, 657, 0, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{1504, 0, 752, 0, 0, 0, 0, 0, 1, 0};
        tbl[10] = '{1506, 0, 753, 0, 0, 0, 0, 1, 1, 0};
        tbl[11] = '{1599, 1, 799, 0, 0, 0, 0, 1, 1, 0};
        tbl[12] = '{1600, 0,   0, 1, 0, 0, 0, 1, 1, 0};
        tbl[13] = '{1601, 1,   0, 1, 1, 0, 0, 1, 1, 0};
        tbl[14] = '{1602, 0,   1, 1, 0, 0, 1, 1, 1, 0};

        resetN = 1'b1;
        #2 resetN = 1'b0;
        repeat (5) @(posedge CLK_50);
        #1;
        check("rst pix_en",       int'(if_a.pix_en),       0);
        check("rst pixel_x",      int'(if_a.pixel_x),      0);
        check("rst pixel_y",      int'(if_a.pixel_y),      0);
        check("rst line_start",   int'(if_a.line_start),   0);
        check("rst frame_start",  int'(if_a.frame_start),  0);
        check("rst video_active", int'(if_a.video_active), 0);
        check("rst h_sync",       int'(if_a.h_sync),       1);
        check("rst v_sync",       int'(if_a.v_sync),       1);
        check("rst c h_sync",     int'(if_c.h_sync),       0);
        check("rst c v_sync",     int'(if_c.v_sync),       0);

        @(negedge CLK_50);
        resetN = 1'b1;
        ka = 0;
        kd = 0;
        fork
            run_vec(0, 14, ka);
            begin
                step_to(kd, 161);
                check("d v_sync before fall", int'(if_d.v_sync), 1);
                step_to(kd, 162);
                check("d v_sync fall", int'(if_d.v_sync), 0);
                step_to(kd, 255);
                check("d last x", int'(if_d.pixel_x), 15);
                check("d last y", int'(if_d.pixel_y), 7);
                check("d last line_start", int'(if_d.line_start), 0);
                step_to(kd, 257);
                check("d wrap frame_start", int'(if_d.frame_start), 1);
                check("d wrap line_start",  int'(if_d.line_start),  1);
                check("d wrap x", int'(if_d.pixel_x), 0);
                check("d wrap y", int'(if_d.pixel_y), 0);
                fs_cnt = 0; vlow = 0; hlow = 0; first_fs = -1; fs_gap = 0;
                for (int j = 0; j < 512; j++) begin
                    @(posedge CLK_50);
                    kd++;
                    #1;
                    if (if_d.frame_start) begin
                        if (first_fs < 0) first_fs = kd;
                        else if (fs_gap == 0) fs_gap = kd - first_fs;
                        fs_cnt++;
                    end
                    if (!if_d.v_sync) vlow++;
                    if (!if_d.h_sync) hlow++;
                end
                check("d frame_start count", fs_cnt, 2);
                check("d frame period", fs_gap, 256);
                check("d v_sync low clocks", vlow, 128);
                check("d h_sync low clocks", hlow, 96);
            end
        join

        km = ka;
        step_to(km, 3200);
        ls_cnt = 0; hlow = 0; vlow = 0;
        for (int j = 0; j < 1600; j++) begin
            @(posedge CLK_50);
            km++;
            #1;
            if (if_a.line_start) ls_cnt++;
            if (!if_a.h_sync) hlow++;
            if (!if_a.v_sync) vlow++;
        end
        check("line_start per line", ls_cnt, 1);
        check("h_sync low per line", hlow, 192);
        check("v_sync low early lines", vlow, 0);

        step_to(km, 5600);
        check("mid pixel_x", int'(if_a.pixel_x), 400);
        check("mid pixel_y", int'(if_a.pixel_y), 3);
        check("mid video_active", int'(if_a.video_active), 1);
        resetN = 1'b0;
        #1;
        check("async pixel_x",      int'(if_a.pixel_x),      0);
        check("async pixel_y",      int'(if_a.pixel_y),      0);
        check("async pix_en",       int'(if_a.pix_en),       0);
        check("async video_active", int'(if_a.video_active), 0);
        check("async h_sync",       int'(if_a.h_sync),       1);
        check("async v_sync",       int'(if_a.v_sync),       1);
        repeat (3) @(posedge CLK_50);
        @(negedge CLK_50);
        resetN = 1'b1;
        km = 0;
        run_vec(0, 2, km);

        repeat (4) @(posedge CLK_50);
        #1;
        check("sync inversion bad cycles", inv_bad, 0);
        check("sync inversion sampled", int'(inv_n > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640×480@60 Hz VGA output path.
- Divides CLK_50 into a 25 MHz pixel enable and maintains horizontal/vertical counters.
- Drives pixel_x/pixel_y to the address generator and the hex/perf overlays, and drives h_sync/v_sync/video_active to the vga stage.
- Sync and blanking are delayed by a fixed number of CLK_50 cycles so they line up with pixel data that went through the 1-cycle VGA RAM read and the overlay logic.

## Interface
Clocking and reset (already decided): one clock, CLK_50; reset resetN, asynchronous, active-low.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible lines
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines
- SYNC_ACTIVE_LOW, 1: 1 means syncs are low while asserted
- PIPE_DELAY, 2: CLK_50 cycles of delay on sync/active relative to the coordinates; legal range 1..4

Ports:
- CLK_50  in  1: system clock, 50 MHz
- resetN  in  1: asynchronous active-low reset
- pix_en  out  1: pixel-tick qualifier; high every second CLK_50 cycle
- pixel_x  out  10: horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10: vertical counter, 0..V_TOTAL-1
- line_start  out  1: 1-cycle pulse, pix_en && pixel_x==0
- frame_start  out  1: 1-cycle pulse, pix_en && pixel_x==0 && pixel_y==0
- video_active  out  1: delayed visible-region flag
- h_sync  out  1: delayed horizontal sync, polarity per SYNC_ACTIVE_LOW
- v_sync  out  1: delayed vertical sync, polarity per SYNC_ACTIVE_LOW

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525 by default).
- Elaboration error if H_TOTAL>1024, V_TOTAL>1024, or PIPE_DELAY is outside 1..4.
- pix_en is a toggle register.
  - Reset value 0; goes to 1 on the first CLK_50 edge after resetN deasserts.
- Counters advance only on edges where pix_en==1.
  - pixel_x increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, pixel_y increments and wraps from V_TOTAL-1 to 0.
  - Both wraps on the same edge give pixel_x=0, pixel_y=0.
- Raw decode from the undelayed counters:
  - active = x<H_ACTIVE && y<V_ACTIVE
  - hs = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- The {active, hs, vs} triple passes through a PIPE_DELAY-deep CLK_50 shift register. It shifts every cycle, not gated by pix_en.
- Output polarity is applied after the delay.
- pixel_x/pixel_y are full counter values, not clamped. Downstream blanks using video_active.

## Timing
- Reset values:
  - pix_en=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0, video_active=0.
  - h_sync/v_sync deasserted: 1 when SYNC_ACTIVE_LOW=1, 0 otherwise.
  - Every delay-line stage resets to {0, deasserted, deasserted}.
- Latency: video_active/h_sync/v_sync at cycle t equal the decode of the counters at cycle t-PIPE_DELAY.
- line_start/frame_start are combinational from registered state, with zero delay.
- Line period is 1600 CLK_50 cycles. Frame period is 840000 CLK_50 cycles (default parameters).
- hs is asserted for exactly H_SYNC pixel ticks (192 CLK_50 cycles) per line.
- vs is asserted for exactly V_SYNC×H_TOTAL pixel ticks per frame.
- Reset mid-frame: all registers clear immediately and asynchronously. After release, the frame restarts at (0,0) with the pipe refilled with inactive entries, so no partial sync pulse appears during the first PIPE_DELAY cycles.
- Simultaneous h-wrap and v-wrap: frame_start and line_start pulse in the same cycle.

## Structure
- Package vga_pkg holds:
  - default timing constants (H_ACTIVE … V_BP, as localparams);
  - typedef struct packed {logic active; logic hs; logic vs;} vga_ctl_t;
  - a function computing H_TOTAL/V_TOTAL.
- Sub-module sig_delay: generic parameterised shift register (WIDTH, DEPTH, RESET_VALUE), async active-low reset. It carries vga_ctl_t.
- Counters, pix_en and the decode stay in vga_timing_gen.

## Test plan
- Hold resetN=0 for 5 cycles → all outputs at their reset values. Release → pix_en=1 on the first edge; pixel_x=1 after that edge.
- Run 1 line → pixel_x reaches 799 and wraps to 0; line_start pulses once; pixel_y becomes 1; hs pulse (pre-delay) spans x=656..751.
- Run 1 full frame → frame_start pulses exactly once per 840000 cycles; v_sync low for 2×800 pixel ticks starting at y=490, x=0 (+PIPE_DELAY).
- PIPE_DELAY=3 → video_active falls exactly 3 CLK_50 cycles after pixel_x first equals 640.
- Assert resetN mid-line at x=400, y=200 → counters read 0 in the same cycle, h_sync/v_sync deasserted; restart matches the fresh-reset trace.
- SYNC_ACTIVE_LOW=0 → h_sync/v_sync waveforms are the exact inverse of the default run.
